// File: rtl/mroi_packet_scheduler.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mroi_packet_scheduler: sequences LEADER/PAYLOAD/TRAILER packets per frame    |
// | Rev 1.0                                                                      |
// +-----------------------------------------------------------------------------+
module mroi_packet_scheduler #(
   parameter int REG_WD             = 32,
   parameter int MROI_MAX_NUM       = 16,
   parameter int LEADER_SIZE        = 52,
   parameter int TRAILER_SIZE       = 32,
   parameter int TRAILER_CHUNK_SIZE = 36
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           i_multi_roi_total_en,
   input  logic                           i_chunkmodeactive,
   input  logic                           i_framebuffer_empty,
   input  logic [7:0]                     iv_roi_num,
   input  logic [REG_WD*MROI_MAX_NUM-1:0] iv_payload_size_mroi,
   input  logic                           i_change_flag,
   output logic                           o_leader_flag,
   output logic                           o_payload_flag,
   output logic                           o_trailer_flag,
   output logic [REG_WD-1:0]              ov_packet_size,
   output logic [7:0]                     ov_roi_idx,
   output logic                           o_roi_err,
   output logic                           o_frame_done,
   output logic [15:0]                    ov_frame_cnt
);

   localparam logic [1:0] c_ST_IDLE    = 2'd0;
   localparam logic [1:0] c_ST_LEADER  = 2'd1;
   localparam logic [1:0] c_ST_PAYLOAD = 2'd2;
   localparam logic [1:0] c_ST_TRAILER = 2'd3;

   localparam int c_IDX_W = (MROI_MAX_NUM > 1) ? $clog2(MROI_MAX_NUM) : 1;

   logic [1:0]        r_state;
   logic              r_multi;
   logic              r_chunk;
   logic              r_leader;
   logic              r_payload;
   logic              r_trailer;
   logic [REG_WD-1:0] r_packet_size;
   logic [7:0]        r_roi_idx;
   logic              r_roi_err;
   logic              r_frame_done;
   logic [15:0]       r_frame_cnt;

   logic [REG_WD-1:0] w_slot [MROI_MAX_NUM];
   logic              w_roi_in_range;
   logic [7:0]        w_sel_idx;
   logic [REG_WD-1:0] w_sel_size;
   logic [REG_WD-1:0] w_trailer_size;

   generate
      for (genvar k = 0; k < MROI_MAX_NUM; k++) begin : g_slot
         assign w_slot[k] = iv_payload_size_mroi[k*REG_WD +: REG_WD];
      end
   endgenerate

   // Out-of-range ROI numbers fall back to slot 0, so the slot index never exceeds the array.
   assign w_roi_in_range = ({1'b0, iv_roi_num} < 9'(MROI_MAX_NUM));
   assign w_sel_idx      = (r_multi && w_roi_in_range) ? iv_roi_num : 8'd0;
   assign w_sel_size     = w_slot[w_sel_idx[c_IDX_W-1:0]];
   assign w_trailer_size = r_chunk ? REG_WD'(TRAILER_CHUNK_SIZE) : REG_WD'(TRAILER_SIZE);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= c_ST_IDLE;
         r_multi       <= 1'b0;
         r_chunk       <= 1'b0;
         r_leader      <= 1'b0;
         r_payload     <= 1'b0;
         r_trailer     <= 1'b0;
         r_packet_size <= '0;
         r_roi_idx     <= 8'd0;
         r_roi_err     <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_cnt   <= 16'd0;
      end else begin
         r_roi_err    <= 1'b0;
         r_frame_done <= 1'b0;
         case (r_state)
            c_ST_IDLE: begin
               if (!i_framebuffer_empty) begin
                  r_state       <= c_ST_LEADER;
                  r_multi       <= i_multi_roi_total_en;
                  r_chunk       <= i_chunkmodeactive;
                  r_leader      <= 1'b1;
                  r_packet_size <= REG_WD'(LEADER_SIZE);
               end
            end
            c_ST_LEADER: begin
               if (i_change_flag) begin
                  r_leader  <= 1'b0;
                  r_roi_idx <= w_sel_idx;
                  r_roi_err <= r_multi && !w_roi_in_range;
                  // An empty ROI payload skips the PAYLOAD packet entirely.
                  if (w_sel_size != '0) begin
                     r_state       <= c_ST_PAYLOAD;
                     r_payload     <= 1'b1;
                     r_packet_size <= w_sel_size;
                  end else begin
                     r_state       <= c_ST_TRAILER;
                     r_trailer     <= 1'b1;
                     r_packet_size <= w_trailer_size;
                  end
               end
            end
            c_ST_PAYLOAD: begin
               if (i_change_flag) begin
                  r_state       <= c_ST_TRAILER;
                  r_payload     <= 1'b0;
                  r_trailer     <= 1'b1;
                  r_packet_size <= w_trailer_size;
               end
            end
            c_ST_TRAILER: begin
               if (i_change_flag) begin
                  r_state      <= c_ST_IDLE;
                  r_trailer    <= 1'b0;
                  r_frame_done <= 1'b1;
                  r_frame_cnt  <= r_frame_cnt + 16'd1;
               end
            end
            default: begin
               r_state   <= c_ST_IDLE;
               r_leader  <= 1'b0;
               r_payload <= 1'b0;
               r_trailer <= 1'b0;
            end
         endcase
      end
   end

   assign o_leader_flag  = r_leader;
   assign o_payload_flag = r_payload;
   assign o_trailer_flag = r_trailer;
   assign ov_packet_size = r_packet_size;
   assign ov_roi_idx     = r_roi_idx;
   assign o_roi_err      = r_roi_err;
   assign o_frame_done   = r_frame_done;
   assign ov_frame_cnt   = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mroi_packet_scheduler.sv
`default_nettype none
// Testbench for mroi_packet_scheduler: frame-level reference model feeding a scoreboard
// that a negedge monitor drains whenever the DUT emits a packet, error or frame-done event.
module tb_mroi_packet_scheduler;

   localparam int REG_WD = 32;
   localparam int MAXN   = 16;

   localparam int K_LEAD = 0;
   localparam int K_PAY  = 1;
   localparam int K_TRL  = 2;
   localparam int K_DONE = 3;
   localparam int K_ERR  = 4;

   typedef struct {
      int          kind;
      logic [31:0] val;
      logic [7:0]  idx;
      bit          chk_idx;
      longint      cyc;
   } ev_t;

   logic                    clk = 1'b0;
   logic                    reset = 1'b1;
   logic                    i_multi_roi_total_en = 1'b0;
   logic                    i_chunkmodeactive = 1'b0;
   logic                    i_framebuffer_empty = 1'b1;
   logic [7:0]              iv_roi_num = 8'd0;
   logic [REG_WD*MAXN-1:0]  iv_payload_size_mroi;
   logic                    i_change_flag = 1'b0;
   logic                    o_leader_flag, o_payload_flag, o_trailer_flag;
   logic [REG_WD-1:0]       ov_packet_size;
   logic [7:0]              ov_roi_idx;
   logic                    o_roi_err, o_frame_done;
   logic [15:0]             ov_frame_cnt;

   logic [31:0] slots [MAXN];
   ev_t         sb [$];
   longint      cyc = 0;
   logic        rst_q = 1'b0;
   logic [2:0]  prev_flags = 3'b000;
   logic [15:0] m_cnt = 16'd0;
   int          checks = 0;
   int          errors = 0;
   bit          stim_done = 1'b0;
   bit          final_done = 1'b0;

   wire logic [2:0] w_flags = {o_leader_flag, o_payload_flag, o_trailer_flag};

   mroi_packet_scheduler #(
      .REG_WD(REG_WD), .MROI_MAX_NUM(MAXN), .LEADER_SIZE(52),
      .TRAILER_SIZE(32), .TRAILER_CHUNK_SIZE(36)
   ) dut (
      .clk(clk), .reset(reset),
      .i_multi_roi_total_en(i_multi_roi_total_en),
      .i_chunkmodeactive(i_chunkmodeactive),
      .i_framebuffer_empty(i_framebuffer_empty),
      .iv_roi_num(iv_roi_num),
      .iv_payload_size_mroi(iv_payload_size_mroi),
      .i_change_flag(i_change_flag),
      .o_leader_flag(o_leader_flag), .o_payload_flag(o_payload_flag),
      .o_trailer_flag(o_trailer_flag), .ov_packet_size(ov_packet_size),
      .ov_roi_idx(ov_roi_idx), .o_roi_err(o_roi_err),
      .o_frame_done(o_frame_done), .ov_frame_cnt(ov_frame_cnt)
   );

   always #5 clk = ~clk;

   always_comb begin
      iv_payload_size_mroi = '0;
      for (int k = 0; k < MAXN; k++) iv_payload_size_mroi[k*REG_WD +: REG_WD] = slots[k];
   end

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   // ---------------- monitor ----------------
   task automatic chk_ev(input int kind, input logic [31:0] val, input logic [7:0] idx);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_event: got kind=%0d val=%0h idx=%0d cyc=%0d, required no event",
                  kind, val, idx, cyc);
         return;
      end
      e = sb.pop_front();
      if (e.kind != kind || e.val != val || e.cyc != cyc || (e.chk_idx && e.idx != idx)) begin
         errors++;
         $display("FAIL event_k%0d: got kind=%0d val=%0h idx=%0d cyc=%0d, required kind=%0d val=%0h idx=%0d cyc=%0d",
                  e.kind, kind, val, idx, cyc, e.kind, e.val, e.idx, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_q) begin
         checks++;
         if (w_flags != 3'b000 || ov_packet_size != '0 || ov_roi_idx != 8'd0 ||
             o_roi_err || o_frame_done || ov_frame_cnt != 16'd0) begin
            errors++;
            $display("FAIL reset_state: got flags=%b size=%0h idx=%0d err=%b done=%b cnt=%0d, required all zero",
                     w_flags, ov_packet_size, ov_roi_idx, o_roi_err, o_frame_done, ov_frame_cnt);
         end
         prev_flags <= 3'b000;
      end else begin
         while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed_event: got nothing at cyc=%0d, required kind=%0d val=%0h",
                     sb[0].cyc, sb[0].kind, sb[0].val);
            void'(sb.pop_front());
         end
         checks++;
         if ($countones(w_flags) > 1) begin
            errors++;
            $display("FAIL flags_onehot: got flags=%b, required at most one high", w_flags);
         end
         if (o_roi_err) chk_ev(K_ERR, 32'd0, 8'd0);
         if (w_flags != prev_flags && w_flags != 3'b000) begin
            case (w_flags)
               3'b100:  chk_ev(K_LEAD, ov_packet_size, ov_roi_idx);
               3'b010:  chk_ev(K_PAY,  ov_packet_size, ov_roi_idx);
               3'b001:  chk_ev(K_TRL,  ov_packet_size, ov_roi_idx);
               default: chk_ev(9,      ov_packet_size, ov_roi_idx);
            endcase
         end
         if (o_frame_done) chk_ev(K_DONE, {16'd0, ov_frame_cnt}, 8'd0);
         prev_flags <= w_flags;
      end
      if (stim_done && !final_done) begin
         checks++;
         if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending events, required 0", sb.size());
         end
         final_done <= 1'b1;
      end
   end

   // ---------------- stimulus + reference model ----------------
   task automatic push(input int kind, input logic [31:0] val, input logic [7:0] idx, input bit ci);
      ev_t e;
      e.kind = kind; e.val = val; e.idx = idx; e.chk_idx = ci; e.cyc = cyc + 1;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // In-frame noise: empty, mode and ROI inputs must all be ignored here.
   task automatic frame_noise();
      i_change_flag        = 1'b0;
      i_framebuffer_empty  = 1'($urandom_range(0, 1));
      i_multi_roi_total_en = 1'($urandom_range(0, 1));
      i_chunkmodeactive    = 1'($urandom_range(0, 1));
      iv_roi_num           = 8'($urandom);
   endtask

   task automatic gap();
      repeat ($urandom_range(0, 2)) begin
         tick();
         frame_noise();
      end
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         tick();
         i_change_flag        = 1'($urandom_range(0, 1));
         i_framebuffer_empty  = 1'b1;
         i_multi_roi_total_en = 1'($urandom_range(0, 1));
         i_chunkmodeactive    = 1'($urandom_range(0, 1));
         iv_roi_num           = 8'($urandom);
      end
   endtask

   task automatic run_frame(input bit m, input bit ch, input logic [7:0] roi, input bit b2b);
      logic [7:0]  idx;
      logic [31:0] sz, tsz;
      bit          err;
      tick();
      i_change_flag = 1'b0; i_multi_roi_total_en = m; i_chunkmodeactive = ch;
      i_framebuffer_empty = 1'b0; iv_roi_num = 8'($urandom);
      push(K_LEAD, 32'd52, 8'd0, 1'b0);
      idx = (m && roi < MAXN) ? roi : 8'd0;
      err = m && (roi >= MAXN);
      sz  = slots[idx];
      tsz = ch ? 32'd36 : 32'd32;
      gap();
      tick(); frame_noise(); iv_roi_num = roi; i_change_flag = 1'b1;
      if (err) push(K_ERR, 32'd0, 8'd0, 1'b0);
      if (sz != 0) push(K_PAY, sz, idx, 1'b1);
      else         push(K_TRL, tsz, idx, 1'b1);
      if (sz != 0) begin
         gap();
         tick(); frame_noise(); i_change_flag = 1'b1;
         push(K_TRL, tsz, idx, 1'b1);
      end
      gap();
      tick(); frame_noise(); i_change_flag = 1'b1;
      i_framebuffer_empty = b2b ? 1'b0 : 1'b1;
      m_cnt = m_cnt + 16'd1;
      push(K_DONE, {16'd0, m_cnt}, 8'd0, 1'b0);
   endtask

   initial begin
      bit b2b;
      for (int k = 0; k < MAXN; k++) slots[k] = 32'h100 + 32'(k);
      repeat (3) tick();
      reset = 1'b0;
      idle_cycles(2);

      slots[0] = 32'h1000;
      run_frame(1'b0, 1'b0, 8'd7, 1'b0);  idle_cycles(2);
      slots[5] = 32'h800;
      run_frame(1'b1, 1'b1, 8'd5, 1'b0);  idle_cycles(2);
      slots[0] = 32'h1234;
      run_frame(1'b1, 1'b0, 8'd20, 1'b0); idle_cycles(2);
      slots[0] = 32'h0;
      run_frame(1'b0, 1'b1, 8'd3, 1'b0);  idle_cycles(2);
      slots[0] = 32'h40;
      run_frame(1'b0, 1'b0, 8'd0, 1'b1);
      run_frame(1'b0, 1'b1, 8'd0, 1'b0);  idle_cycles(2);

      // Reset while in PAYLOAD with a coincident change pulse: no frame_done may follow.
      slots[0] = 32'h300;
      tick();
      i_change_flag = 1'b0; i_multi_roi_total_en = 1'b0; i_chunkmodeactive = 1'b0;
      i_framebuffer_empty = 1'b0;
      push(K_LEAD, 32'd52, 8'd0, 1'b0);
      tick(); frame_noise(); iv_roi_num = 8'd0; i_change_flag = 1'b1;
      push(K_PAY, 32'h300, 8'd0, 1'b1);
      tick(); frame_noise();
      tick(); reset = 1'b1; i_change_flag = 1'b1; i_framebuffer_empty = 1'b1;
      tick(); reset = 1'b0; i_change_flag = 1'b0;
      m_cnt = 16'd0;
      idle_cycles(3);

      // Preset the counter instead of running 65535 frames.
      force dut.r_frame_cnt = 16'hFFFF;
      tick();
      release dut.r_frame_cnt;
      m_cnt = 16'hFFFF;
      idle_cycles(1);
      run_frame(1'b0, 1'b0, 8'd1, 1'b0); idle_cycles(2);

      for (int f = 0; f < 60; f++) begin
         for (int k = 0; k < MAXN; k++)
            slots[k] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
         b2b = 1'($urandom_range(0, 1));
         run_frame(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 31)), b2b);
         if (!b2b) idle_cycles($urandom_range(1, 3));
      end
      idle_cycles(3);

      stim_done = 1'b1;
      repeat (3) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mroi_packet_scheduler.md
MROI_PACKET_SCHEDULER -- requirements
Module: mroi_packet_scheduler

Interface
REQ-001 SHALL have parameter REG_WD, default 32, register/packet-size width in bits.
REQ-002 SHALL have parameter MROI_MAX_NUM, default 16, number of ROI payload-size slots (1..256).
REQ-003 SHALL have parameter LEADER_SIZE, default 52, leader byte count.
REQ-004 SHALL have parameter TRAILER_SIZE, default 32, trailer byte count with chunk off.
REQ-005 SHALL have parameter TRAILER_CHUNK_SIZE, default 36, trailer byte count with chunk on.
REQ-006 SHALL have port clk  input  1  single clock (clk_usb_pclk domain).
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have port i_multi_roi_total_en  input  1  1 = multi-ROI, 0 = single-ROI.
REQ-009 SHALL have port i_chunkmodeactive  input  1  chunk master switch; selects trailer size.
REQ-010 SHALL have port i_framebuffer_empty  input  1  framebuffer output FIFO empty, active high.
REQ-011 SHALL have port iv_roi_num  input  8  ROI number parsed from leader; valid in the cycle i_change_flag is high in LEADER.
REQ-012 SHALL have port iv_payload_size_mroi  input  REG_WD*MROI_MAX_NUM  payload sizes; slot k = bits [k*REG_WD +: REG_WD].
REQ-013 SHALL have port i_change_flag  input  1  one-cycle pulse: current packet fully transferred.
REQ-014 SHALL have port o_leader_flag / o_payload_flag / o_trailer_flag  output  1 each  registered, one-hot packet-type flags.
REQ-015 SHALL have port ov_packet_size  output  REG_WD  registered byte size of the current packet.
REQ-016 SHALL have port ov_roi_idx  output  8  ROI slot index in use for the current frame.
REQ-017 SHALL have port o_roi_err  output  1  one-cycle pulse: out-of-range ROI number.
REQ-018 SHALL have port o_frame_done  output  1  one-cycle pulse: trailer completed.
REQ-019 SHALL have port ov_frame_cnt  output  16  count of completed frames, wraps at 0xFFFF -> 0.

Function
REQ-020 SHALL implement FSM states IDLE, LEADER, PAYLOAD, TRAILER; at most one of the three flags is high, and all are low in IDLE.
REQ-021 SHALL, in IDLE with i_framebuffer_empty=0, enter LEADER next cycle and drive ov_packet_size=LEADER_SIZE; i_change_flag is ignored in IDLE.
REQ-022 SHALL latch i_multi_roi_total_en and i_chunkmodeactive on IDLE->LEADER and hold them until the frame returns to IDLE; mid-frame input changes have no effect.
REQ-023 SHALL, on i_change_flag in LEADER, select slot index = iv_roi_num when multi-ROI is latched and iv_roi_num < MROI_MAX_NUM, else slot 0; ov_roi_idx updates in the same cycle as the state change.
REQ-024 SHALL pulse o_roi_err for one cycle when multi-ROI is latched and iv_roi_num >= MROI_MAX_NUM; the frame continues using slot 0.
REQ-025 SHALL, leaving LEADER, enter PAYLOAD with ov_packet_size = selected slot value; if that value is 0, enter TRAILER directly (PAYLOAD never asserted).
REQ-026 SHALL, on i_change_flag in PAYLOAD, enter TRAILER with ov_packet_size = TRAILER_CHUNK_SIZE if latched chunk=1, else TRAILER_SIZE.
REQ-027 SHALL, on i_change_flag in TRAILER, return to IDLE, pulse o_frame_done, and increment ov_frame_cnt; a new LEADER may start on the following cycle.
REQ-028 SHALL make every transition, flag, and size update exactly 1 clk after the triggering i_change_flag or empty sample, with no combinational input-to-output paths.
REQ-029 SHALL ignore i_framebuffer_empty outside IDLE.

Reset
REQ-030 SHALL, while reset=1 at a clk edge, force state IDLE, all flags 0, ov_packet_size=0, ov_roi_idx=0, o_roi_err=0, o_frame_done=0, ov_frame_cnt=0, latched mode bits 0.
REQ-031 SHALL, on reset mid-frame, abort the frame without pulsing o_frame_done, and SHALL ignore i_change_flag coincident with reset.

Verification
REQ-032 SHALL verify: single-ROI, chunk=0, slot0=0x1000, empty falls, 3 change pulses -> sizes 52, 0x1000, 32; one o_frame_done; ov_frame_cnt=1.
REQ-033 SHALL verify: multi-ROI, iv_roi_num=5, slot5=0x800, chunk=1 -> ov_roi_idx=5; sizes 52, 0x800, 36.
REQ-034 SHALL verify: multi-ROI, iv_roi_num=20 (MROI_MAX_NUM=16) -> o_roi_err single pulse; slot 0 size used.
REQ-035 SHALL verify: selected slot=0 -> LEADER goes straight to TRAILER; o_payload_flag never high.
REQ-036 SHALL verify: chunk toggled during PAYLOAD -> trailer size follows the value latched at frame start; reset asserted in PAYLOAD -> next cycle all outputs 0, no o_frame_done.
REQ-037 SHALL verify: ov_frame_cnt preset by 65535 frames -> next frame wraps it to 0.
